// File: rtl/rgb_block_assembler.sv
// rgb_block_assembler: packs serial RGB pixels into ping-pong 8x8 blocks of three 512-bit buses
module rgb_block_assembler #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PIX_W-1:0]         R_in,
  input  logic [PIX_W-1:0]         G_in,
  input  logic [PIX_W-1:0]         B_in,
  output logic [PIX_W*N_PIX-1:0]   R_8in8,
  output logic [PIX_W*N_PIX-1:0]   G_8in8,
  output logic [PIX_W*N_PIX-1:0]   B_8in8,
  output logic                     block_valid,
  input  logic                     block_ready,
  output logic [1:0]               blocks_pending
);
  localparam int BW = PIX_W * N_PIX;
  localparam int CW = $clog2(N_PIX);
  logic [BW-1:0] r_buf [2];
  logic [BW-1:0] g_buf [2];
  logic [BW-1:0] b_buf [2];
  logic          wr_sel, rd_sel;
  logic [CW-1:0] wr_cnt;
  logic [1:0]    full, full_nxt;
  logic          accept, consume, last;
  // handshakes decoded from registered flags only; a full buffer is never written
  always_comb begin
    pix_ready      = !full[wr_sel];
    block_valid    = full[rd_sel];
    accept         = pix_valid && pix_ready;
    consume        = block_valid && block_ready;
    last           = accept && (wr_cnt == CW'(N_PIX - 1));
    full_nxt       = (full & ~(consume ? 2'(1) << rd_sel : 2'b00)) | (last ? 2'(1) << wr_sel : 2'b00);
    blocks_pending = 2'(full[0]) + 2'(full[1]);
    R_8in8         = r_buf[rd_sel];
    G_8in8         = g_buf[rd_sel];
    B_8in8         = b_buf[rd_sel];
  end
  // pixel writes into the fill buffer, pointer toggles and full-flag update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf  <= '{default: '0};
      g_buf  <= '{default: '0};
      b_buf  <= '{default: '0};
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      full   <= 2'b00;
    end else begin
      if (accept) begin
        r_buf[wr_sel][wr_cnt*PIX_W +: PIX_W] <= R_in;
        g_buf[wr_sel][wr_cnt*PIX_W +: PIX_W] <= G_in;
        b_buf[wr_sel][wr_cnt*PIX_W +: PIX_W] <= B_in;
        wr_cnt <= wr_cnt + CW'(1);
      end
      if (last) wr_sel <= ~wr_sel;
      if (consume) rd_sel <= ~rd_sel;
      full <= full_nxt;
    end
  end
endmodule

// File: tb/tb_rgb_block_assembler.sv
// tb_rgb_block_assembler: table-driven and randomized checks against a pixel-history model
module tb_rgb_block_assembler;
  logic         clk = 0, reset = 1, pix_valid = 0, block_ready = 0;
  logic [7:0]   R_in = 0, G_in = 0, B_in = 0;
  logic         pix_ready, block_valid;
  logic [511:0] R_8in8, G_8in8, B_8in8;
  logic [1:0]   blocks_pending;

  rgb_block_assembler dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .R_8in8(R_8in8), .G_8in8(G_8in8), .B_8in8(B_8in8),
    .block_valid(block_valid), .block_ready(block_ready), .blocks_pending(blocks_pending)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [23:0] hist[$];
  int consumed = 0;
  int src_idx = 0;
  logic [23:0] src_pix = 24'h0;
  bit rnd = 0;
  int vcount = 0, rlow = 0;

  typedef struct {
    bit rst, pv, br;
    int n;
    bit er, ev;
    logic [1:0] ep;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [23:0] pat(int i);
    logic [7:0] r, g, b;
    r = 8'(i);
    g = 8'(i + 64);
    b = 8'(255 - i);
    return {r, g, b};
  endfunction

  function automatic logic [511:0] ramp(int off, int dir);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[8*k +: 8] = 8'(off + dir * k);
    return v;
  endfunction

  function automatic int nfull();
    return hist.size() / 64 - consumed;
  endfunction

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_check();
    logic [511:0] er, eg, eb;
    int base;
    chk("pix_ready", 512'(pix_ready), 512'(nfull() < 2));
    chk("block_valid", 512'(block_valid), 512'(nfull() > 0));
    chk("blocks_pending", 512'(blocks_pending), 512'(nfull()));
    if (nfull() > 0) begin
      base = 64 * consumed;
      for (int k = 0; k < 64; k++) begin
        er[8*k +: 8] = hist[base+k][23:16];
        eg[8*k +: 8] = hist[base+k][15:8];
        eb[8*k +: 8] = hist[base+k][7:0];
      end
      chk("R_8in8", R_8in8, er);
      chk("G_8in8", G_8in8, eg);
      chk("B_8in8", B_8in8, eb);
    end
  endtask

  task automatic cyc(input bit rst, input bit pv, input bit br);
    bit acc, con;
    reset = rst;
    pix_valid = pv;
    block_ready = br;
    {R_in, G_in, B_in} = src_pix;
    acc = !rst && pv && nfull() < 2;
    con = !rst && br && nfull() > 0;
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete();
      consumed = 0;
      src_idx = 0;
      src_pix = rnd ? 24'($urandom) : pat(0);
    end else begin
      if (con) consumed++;
      if (acc) begin
        hist.push_back(src_pix);
        src_idx++;
        src_pix = rnd ? 24'($urandom) : pat(src_idx);
      end
    end
    if (block_valid) vcount++;
    if (!pix_ready) rlow++;
    model_check();
  endtask

  initial begin
    logic [23:0] first;
    int guard;
    tbl[0]  = '{1, 0, 0, 1,   1, 0, 2'd0};
    tbl[1]  = '{0, 1, 1, 63,  1, 0, 2'd0};
    tbl[2]  = '{0, 1, 1, 1,   1, 1, 2'd1};
    tbl[3]  = '{0, 0, 1, 1,   1, 0, 2'd0};
    tbl[4]  = '{1, 0, 0, 1,   1, 0, 2'd0};
    tbl[5]  = '{0, 1, 0, 128, 0, 1, 2'd2};
    tbl[6]  = '{0, 1, 0, 2,   0, 1, 2'd2};
    tbl[7]  = '{0, 1, 1, 1,   1, 1, 2'd1};
    tbl[8]  = '{0, 1, 0, 1,   1, 1, 2'd1};
    tbl[9]  = '{0, 1, 0, 62,  1, 1, 2'd1};
    tbl[10] = '{0, 1, 1, 1,   1, 1, 2'd1};
    tbl[11] = '{0, 0, 1, 1,   1, 0, 2'd0};
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].n) cyc(tbl[i].rst, tbl[i].pv, tbl[i].br);
      chk($sformatf("tbl%0d ready", i), 512'(pix_ready), 512'(tbl[i].er));
      chk($sformatf("tbl%0d valid", i), 512'(block_valid), 512'(tbl[i].ev));
      chk($sformatf("tbl%0d pending", i), 512'(blocks_pending), 512'(tbl[i].ep));
      if (i == 0) begin
        chk("reset R", R_8in8, 512'd0);
        chk("reset G", G_8in8, 512'd0);
        chk("reset B", B_8in8, 512'd0);
      end
      if (i == 2) begin
        chk("basic R", R_8in8, ramp(0, 1));
        chk("basic G", G_8in8, ramp(64, 1));
        chk("basic B", B_8in8, ramp(255, -1));
      end
      if (i == 6) chk("bp block0 R", R_8in8, ramp(0, 1));
      if (i == 7) chk("bp block1 R", R_8in8, ramp(64, 1));
      if (i == 10) chk("simul new block R", R_8in8, ramp(128, 1));
    end

    rnd = 1;
    cyc(1, 0, 0);
    repeat (64) cyc(0, 1, 0);
    repeat (30) cyc(0, 1, 0);
    cyc(1, 1, 1);
    chk("midrst R", R_8in8, 512'd0);
    chk("midrst G", G_8in8, 512'd0);
    chk("midrst B", B_8in8, 512'd0);
    chk("midrst ready", 512'(pix_ready), 512'd1);
    chk("midrst pending", 512'(blocks_pending), 512'd0);
    first = src_pix;
    repeat (64) cyc(0, 1, 0);
    chk("midrst first pixel", 512'({R_8in8[7:0], G_8in8[7:0], B_8in8[7:0]}), 512'(first));

    cyc(1, 0, 0);
    guard = 0;
    while (hist.size() < 192 && guard < 2000) begin
      cyc(0, 1'($urandom % 2), 1);
      guard++;
    end
    chk("gapped accepted", 512'(hist.size()), 512'd192);
    repeat (2) cyc(0, 0, 1);
    chk("gapped drained", 512'(blocks_pending), 512'd0);

    cyc(1, 0, 0);
    vcount = 0;
    rlow = 0;
    repeat (640) cyc(0, 1, 1);
    chk("stream valid pulses", 512'(vcount), 512'd10);
    chk("stream ready lows", 512'(rlow), 512'd0);

    repeat (1500) cyc(0, 1'($urandom % 4 != 0), 1'($urandom % 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_block_assembler.md
# rgb_block_assembler

Upstream stage of the colour-conversion block. Accepts a serial stream of RGB pixels, one pixel per accepted clock, and packs every 64 consecutive pixels into one 8x8 block. Each block is presented as three 512-bit buses (R_8in8, G_8in8, B_8in8), which is the format the RGB-to-YCrCb 8x8 stage consumes. Two block buffers (ping-pong) let pixel intake continue while a finished block waits for the downstream stage.

## Interface
Parameters:
- PIX_W, default 8: bits per colour sample. Only the default is supported and verified.
- N_PIX, default 64: pixels per block. Only the default is supported and verified.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- pix_valid  in  1  R_in/G_in/B_in carry a valid pixel.
- pix_ready  out  1  block can accept a pixel this cycle.
- R_in  in  8  red sample.
- G_in  in  8  green sample.
- B_in  in  8  blue sample.
- R_8in8  out  512  red block; pixel k (0..63, arrival order) occupies bits [8k +: 8].
- G_8in8  out  512  green block, same packing as R_8in8.
- B_8in8  out  512  blue block, same packing as R_8in8.
- block_valid  out  1  a complete block is presented on R/G/B_8in8.
- block_ready  in  1  downstream consumes the presented block.
- blocks_pending  out  2  number of full buffers (0..2).

## Operation
- State: buf0 and buf1 (3x512 bits each), wr_sel, rd_sel, wr_cnt[5:0], full[1:0].
- Pixel accept: on posedge when pix_valid && pix_ready. Write R_in/G_in/B_in to buf[wr_sel] at bits [8*wr_cnt +: 8], then wr_cnt += 1.
- Block completion: on an accept with wr_cnt == 63, set full[wr_sel] = 1, wrap wr_cnt to 0 and toggle wr_sel.
- pix_ready = !full[wr_sel]. It is a registered-state decode with no combinational path from pix_valid or block_ready.
- Output: R/G/B_8in8 = buf[rd_sel] (combinational mux of registers). block_valid = full[rd_sel]. blocks_pending = full[0] + full[1].
- Output consume: on posedge when block_valid && block_ready, clear full[rd_sel] and toggle rd_sel. Buffer contents are not cleared. While block_valid is 0, the data outputs show stale buffer contents and must be ignored.
- Simultaneous completion and consume in one cycle: both take effect, because they always target different buffers (a full buffer is never written).
- Both buffers full: wr_sel == rd_sel. A consume frees that buffer, and pix_ready rises in the following cycle. A pixel offered in the consume cycle is not accepted and must be held by the source.
- pix_valid while pix_ready = 0: no state change. Pixel data is ignored and the source holds it.
- Arithmetic: wr_cnt is a 6-bit wrapping counter. No arithmetic is applied to pixel data; samples pass through bit-exact.

## Timing
Reset values (after the posedge with reset = 1):
- wr_cnt = 0, wr_sel = 0, rd_sel = 0, full = 00.
- buf0 = buf1 = 0, so R/G/B_8in8 = 0.
- pix_ready = 1, block_valid = 0, blocks_pending = 0.

Reset behaviour:
- Reset mid-block discards the partial block and any pending full blocks.
- Reset has priority over simultaneous pixel accept and consume.

Latency and throughput:
- Latency: 64th pixel accepted at edge N, so block_valid = 1 from edge N until the consuming edge.
- Throughput: with pix_valid and block_ready held high, one pixel per clock and one block per 64 clocks, with no bubbles.
- Back-pressure: with block_ready = 0, up to 128 pixels are accepted before pix_ready drops. pix_ready goes low at the edge completing the second block.

Handshake rules:
- block_valid, once asserted, stays high and the data stays stable until consumed.
- pix_ready may drop only at a block-completion edge.

## Test plan
- Basic: reset, then stream 64 pixels with R=k, G=k+64, B=255-k and block_ready=1 → block_valid high exactly one cycle after the 64th accept. R_8in8[8k+:8]=k, G_8in8[8k+:8]=k+64, B_8in8[8k+:8]=255-k. block_valid drops after one cycle and blocks_pending returns to 0.
- Back-pressure: block_ready=0, offer 130 pixels (value = index mod 256) → exactly 128 accepted, pix_ready=0, blocks_pending=2. Block 0 is presented first (R_8in8[8k+:8]=k). Pulse block_ready → block 1 is presented (R_8in8[8k+:8]=64+k) and pix_ready rises the next cycle. Pixel 128 is then accepted.
- Gapped input: pix_valid randomly low ~50% of cycles, block_ready=1, 3 blocks → output data bit-exact against the model and no pixel lost or duplicated.
- Simultaneous events: with one block full and wr_cnt=63, drive the 64th pixel and block_ready=1 in the same cycle → the old block is consumed, the new block is valid next cycle, and blocks_pending stays 1.
- Reset mid-operation: accept 30 pixels plus one full block, then assert reset for 1 cycle → all outputs equal 0 and pix_ready=1. The next 64 pixels form a block whose pixel 0 is the first pixel after reset.
- Continuous streaming: 10 blocks with pix_valid=1 and block_ready=1 → block_valid pulses every 64 cycles and pix_ready stays at 1 throughout.
